// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port among two wb ports and a late-result port
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              halt,
    input  logic              we1,
    input  logic [ADDR_W-1:0] tgt1,
    input  logic [DATA_W-1:0] data1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] tgt2,
    input  logic [DATA_W-1:0] data2,
    input  logic              late_valid,
    input  logic [ADDR_W-1:0] late_tgt,
    input  logic [DATA_W-1:0] late_data,
    output logic              late_ready,
    output logic              stall_out,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] hold_tgt;
    logic [DATA_W-1:0] hold_data;

    logic              adv;
    logic              v1;
    logic              v2;
    logic              starved;
    logic              dual_split;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              cap_hold;

    // r0 is never a real write target, so zero targets count as no request
    assign adv        = clk_en && !halt;
    assign v1         = we1 && (tgt1 != '0) && adv;
    assign v2         = we2 && (tgt2 != '0) && adv;
    assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT)) && late_valid;
    assign dual_split = v1 && v2 && (tgt1 != tgt2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a dual write to distinct registers needs one extra cycle to drain port 2
    always_comb begin
        next_state = state;
        if (clk_en) begin
            case (state)
                IDLE:    if (!starved && dual_split) next_state = DRAIN;
                DRAIN:   next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output/select: picks the write source for this cycle and drives the handshakes
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        cap_hold   = 1'b0;
        late_ready = 1'b0;
        stall_out  = 1'b0;
        if (rst_n && clk_en) begin
            case (state)
                IDLE: begin
                    if (starved) begin
                        // wb ports lose this cycle; stalling makes the pipeline re-present them
                        late_ready = 1'b1;
                        stall_out  = adv;
                        sel_we     = (late_tgt != '0);
                        sel_addr   = late_tgt;
                        sel_data   = late_data;
                    end else if (dual_split) begin
                        stall_out  = 1'b1;
                        cap_hold   = 1'b1;
                        sel_we     = 1'b1;
                        sel_addr   = tgt1;
                        sel_data   = data1;
                    end else if (v1) begin
                        sel_we     = 1'b1;
                        sel_addr   = tgt1;
                        sel_data   = data1;
                    end else if (v2) begin
                        sel_we     = 1'b1;
                        sel_addr   = tgt2;
                        sel_data   = data2;
                    end else if (late_valid) begin
                        late_ready = 1'b1;
                        sel_we     = (late_tgt != '0);
                        sel_addr   = late_tgt;
                        sel_data   = late_data;
                    end
                end
                DRAIN: begin
                    // wb inputs now carry the replayed instruction and are ignored
                    sel_we   = 1'b1;
                    sel_addr = hold_tgt;
                    sel_data = hold_data;
                end
                default: ;
            endcase
        end
    end

    // Register-file write stage: one-cycle pulse per selected write, address/data held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (sel_we) begin
            rf_we    <= 1'b1;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Hold entry for the deferred port-2 write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_tgt  <= '0;
            hold_data <= '0;
        end else if (cap_hold) begin
            hold_tgt  <= tgt2;
            hold_data <= data2;
        end
    end

    // Starvation counter: counts cycles a late beat waits, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (clk_en) begin
            if (late_ready) begin
                starve_cnt <= '0;
            end else if (late_valid && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule
